// File: rtl/decode_buffer_stage_pkg.sv
// Shared core types for the decode stage: raw instruction word, decoded
// micro-op entry, opcode constants and immediate extraction helpers.
package decode_buffer_stage_pkg;

    typedef logic [31:0] instruction_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    typedef enum logic [2:0] {
        UOP_ILLEGAL = 3'd0,
        UOP_ALU_REG = 3'd1,
        UOP_ALU_IMM = 3'd2,
        UOP_LOAD    = 3'd3,
        UOP_STORE   = 3'd4,
        UOP_BRANCH  = 3'd5,
        UOP_JUMP    = 3'd6,
        UOP_LUI     = 3'd7
    } uop_e;

    // rd is zero whenever writes_rd is clear, so consumers can use it as-is.
    typedef struct packed {
        logic [31:0] pc;
        uop_e        uop;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [31:0] imm;
        logic        writes_rd;
    } micro_code_t;

    function automatic logic [31:0] imm_i(input instruction_t inst);
        return {{20{inst[31]}}, inst[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input instruction_t inst);
        return {{20{inst[31]}}, inst[31:25], inst[11:7]};
    endfunction

    function automatic logic [31:0] imm_b(input instruction_t inst);
        return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_j(input instruction_t inst);
        return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

    function automatic logic [31:0] imm_u(input instruction_t inst);
        return {inst[31:12], 12'b0};
    endfunction

endpackage

// File: rtl/decode_buffer_stage_decoder.sv
// Purely combinational instruction decoder feeding the buffer's write side.
module decoder
    import decode_buffer_stage_pkg::*;
(
    input  instruction_t inst,
    input  logic [31:0]  inst_pc,
    output micro_code_t  micro_code
);

    logic [6:0] opcode;

    always_comb begin
        opcode               = inst[6:0];
        micro_code           = '0;
        micro_code.pc        = inst_pc;
        micro_code.rd        = inst[11:7];
        micro_code.rs1       = inst[19:15];
        micro_code.rs2       = inst[24:20];
        micro_code.funct3    = inst[14:12];
        micro_code.uop       = UOP_ILLEGAL;
        micro_code.imm       = '0;
        micro_code.writes_rd = 1'b0;
        case (opcode)
            OPC_OP: begin
                micro_code.uop       = UOP_ALU_REG;
                micro_code.writes_rd = 1'b1;
            end
            OPC_OP_IMM: begin
                micro_code.uop       = UOP_ALU_IMM;
                micro_code.imm       = imm_i(inst);
                micro_code.writes_rd = 1'b1;
            end
            OPC_LOAD: begin
                micro_code.uop       = UOP_LOAD;
                micro_code.imm       = imm_i(inst);
                micro_code.writes_rd = 1'b1;
            end
            OPC_STORE: begin
                micro_code.uop = UOP_STORE;
                micro_code.imm = imm_s(inst);
            end
            OPC_BRANCH: begin
                micro_code.uop = UOP_BRANCH;
                micro_code.imm = imm_b(inst);
            end
            OPC_JAL: begin
                micro_code.uop       = UOP_JUMP;
                micro_code.imm       = imm_j(inst);
                micro_code.writes_rd = 1'b1;
            end
            OPC_LUI: begin
                micro_code.uop       = UOP_LUI;
                micro_code.imm       = imm_u(inst);
                micro_code.writes_rd = 1'b1;
            end
            default: begin
                micro_code.uop = UOP_ILLEGAL;
            end
        endcase
        // Non-writing micro-ops carry rd=0 so a stale field never looks like a hazard.
        if (!micro_code.writes_rd) begin
            micro_code.rd = '0;
        end
    end

endmodule

// File: rtl/decode_buffer_stage.sv
// Decode stage: decodes fetched instructions and queues the micro-ops in a
// small FIFO with one cycle of latency from fetch to downstream.
module decode_buffer_stage
    import decode_buffer_stage_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter bit RESET_READY = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         inst_valid,
    output logic                         inst_ready,
    input  instruction_t                 inst,
    input  logic [31:0]                  inst_pc,
    output logic                         micro_code_valid,
    input  logic                         micro_code_ready,
    output micro_code_t                  micro_code,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0] FULL_COUNT = OCC_W'(DEPTH);

    // Handshake: a transfer happens on a rising edge where valid && ready are
    // both high and flush is low; valid never waits on ready, and the sender
    // holds its payload stable until the transfer edge.

    micro_code_t       mem [DEPTH];
    micro_code_t       decoded;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              first_cycle;
    logic              not_full;
    logic              not_empty;
    logic              do_enq;
    logic              do_deq;

    decoder u_decoder (
        .inst       (inst),
        .inst_pc    (inst_pc),
        .micro_code (decoded)
    );

    always_comb begin
        not_full         = (occupancy < FULL_COUNT);
        not_empty        = (occupancy != '0);
        inst_ready       = (first_cycle ? RESET_READY : not_full) && !flush;
        micro_code_valid = not_empty && !flush;
        do_enq           = inst_valid && inst_ready && rst_n;
        do_deq           = micro_code_valid && micro_code_ready && rst_n;
        micro_code       = mem[rd_ptr];
    end

    // first_cycle marks the cycle right after reset, where inst_ready is fixed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            first_cycle <= 1'b1;
        end else begin
            first_cycle <= 1'b0;
        end
    end

    // Reset and flush both empty the queue; storage itself is never cleared.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (do_enq) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_deq) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_enq, do_deq})
                2'b10:   occupancy <= occupancy + OCC_W'(1);
                2'b01:   occupancy <= occupancy - OCC_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_enq) begin
            mem[wr_ptr] <= decoded;
        end
    end

endmodule

// File: tb/tb_decode_buffer_stage.sv
// Directed and stall-randomised checks of the decode buffer stage (DEPTH=4).
module tb_decode_buffer_stage;
    import decode_buffer_stage_pkg::*;

    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         inst_valid = 1'b0;
    logic         inst_ready;
    instruction_t inst = '0;
    logic [31:0]  inst_pc = '0;
    logic         micro_code_valid;
    logic         micro_code_ready = 1'b0;
    micro_code_t  micro_code;
    logic [2:0]   occupancy;

    int tests_run = 0;
    int tests_failed = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    decode_buffer_stage #(.DEPTH(DEPTH), .RESET_READY(1'b1)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .flush            (flush),
        .inst_valid       (inst_valid),
        .inst_ready       (inst_ready),
        .inst             (inst),
        .inst_pc          (inst_pc),
        .micro_code_valid (micro_code_valid),
        .micro_code_ready (micro_code_ready),
        .micro_code       (micro_code),
        .occupancy        (occupancy)
    );

    function automatic instruction_t r_type(input logic [4:0] rd);
        return {7'b0, 5'd0, 5'd0, 3'b0, rd, 7'h33};
    endfunction

    // Push n instructions with downstream stalled; pcs start at base.
    task automatic push_stalled(input logic [31:0] base, input int n);
        micro_code_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            inst_valid = 1'b1;
            inst_pc    = base + 32'(4 * i);
            inst       = r_type(5'd1);
        end
        @(negedge clk);
        inst_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (occupancy !== 3'd0) begin
            tests_failed++;
            $display("FAIL reset_occupancy got %0d want 0", occupancy);
        end
        tests_run++;
        if (micro_code_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_valid got %b want 0", micro_code_valid);
        end
        tests_run++;
        if (inst_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_ready got %b want 1", inst_ready);
        end
    endtask

    task automatic test_decode;
        instruction_t v_inst [6];
        uop_e         v_uop  [6];
        logic [31:0]  v_imm  [6];
        logic [4:0]   v_rd   [6];
        logic         v_wr   [6];
        v_inst[0] = 32'hFFB10093; v_uop[0] = UOP_ALU_IMM; v_imm[0] = 32'hFFFFFFFB; v_rd[0] = 5'd1; v_wr[0] = 1'b1;
        v_inst[1] = 32'h00532423; v_uop[1] = UOP_STORE;   v_imm[1] = 32'h00000008; v_rd[1] = 5'd0; v_wr[1] = 1'b0;
        v_inst[2] = 32'h123451B7; v_uop[2] = UOP_LUI;     v_imm[2] = 32'h12345000; v_rd[2] = 5'd3; v_wr[2] = 1'b1;
        v_inst[3] = 32'hFE208EE3; v_uop[3] = UOP_BRANCH;  v_imm[3] = 32'hFFFFFFFC; v_rd[3] = 5'd0; v_wr[3] = 1'b0;
        v_inst[4] = 32'h00000000; v_uop[4] = UOP_ILLEGAL; v_imm[4] = 32'h00000000; v_rd[4] = 5'd0; v_wr[4] = 1'b0;
        v_inst[5] = 32'h009403B3; v_uop[5] = UOP_ALU_REG; v_imm[5] = 32'h00000000; v_rd[5] = 5'd7; v_wr[5] = 1'b1;
        micro_code_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            inst_valid = 1'b1;
            inst       = v_inst[i];
            inst_pc    = 32'h80 + 32'(4 * i);
            @(negedge clk);
            inst_valid = 1'b0;
            #1;
            tests_run++;
            if (micro_code_valid !== 1'b1 || micro_code.pc !== 32'h80 + 32'(4 * i)) begin
                tests_failed++;
                $display("FAIL decode_%0d_pc got v=%b pc=%h want v=1 pc=%h", i, micro_code_valid, micro_code.pc, 32'h80 + 32'(4 * i));
            end
            tests_run++;
            if (micro_code.uop !== v_uop[i] || micro_code.imm !== v_imm[i] ||
                micro_code.rd !== v_rd[i] || micro_code.writes_rd !== v_wr[i]) begin
                tests_failed++;
                $display("FAIL decode_%0d_fields got uop=%0d imm=%h rd=%0d wr=%b want uop=%0d imm=%h rd=%0d wr=%b",
                         i, micro_code.uop, micro_code.imm, micro_code.rd, micro_code.writes_rd,
                         v_uop[i], v_imm[i], v_rd[i], v_wr[i]);
            end
        end
    endtask

    task automatic test_latency;
        @(negedge clk);
        micro_code_ready = 1'b1;
        inst_valid = 1'b1;
        inst       = r_type(5'd2);
        inst_pc    = 32'h100;
        #1;
        tests_run++;
        if (micro_code_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL latency_before got %b want 0", micro_code_valid);
        end
        @(negedge clk);
        inst_valid = 1'b0;
        #1;
        tests_run++;
        if (micro_code_valid !== 1'b1 || micro_code.pc !== 32'h100) begin
            tests_failed++;
            $display("FAIL latency_out got v=%b pc=%h want v=1 pc=00000100", micro_code_valid, micro_code.pc);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (micro_code_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL latency_after got %b want 0", micro_code_valid);
        end
    endtask

    task automatic test_full;
        bit accepted;
        int budget;
        micro_code_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            inst_valid = 1'b1;
            inst       = r_type(5'd3);
            inst_pc    = 32'(4 * i);
            #1;
            tests_run++;
            if (inst_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL full_push_%0d_ready got %b want 1", i, inst_ready);
            end
        end
        @(negedge clk);
        inst_pc = 32'h10;
        #1;
        tests_run++;
        if (inst_ready !== 1'b0 || occupancy !== 3'd4) begin
            tests_failed++;
            $display("FAIL full_state got ready=%b occ=%0d want ready=0 occ=4", inst_ready, occupancy);
        end
        exp_q = {32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        accepted = 1'b0;
        budget = 0;
        @(negedge clk);
        micro_code_ready = 1'b1;
        #1;
        tests_run++;
        if (inst_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_no_enq_on_deq got %b want 0", inst_ready);
        end
        while (exp_q.size() != 0 && budget < 20) begin
            if (budget != 0) begin
                @(negedge clk);
                if (accepted) inst_valid = 1'b0;
                #1;
            end
            accepted = inst_valid && inst_ready;
            if (micro_code_valid) begin
                tests_run++;
                if (micro_code.pc !== exp_q[0]) begin
                    tests_failed++;
                    $display("FAIL full_order got pc=%h want pc=%h", micro_code.pc, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
            budget++;
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL full_drain_timeout got %0d left want 0", exp_q.size());
        end
        @(negedge clk);
        inst_valid = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_back_to_back;
        logic [31:0] pc;
        push_stalled(32'h200, 2);
        exp_q = {32'h200, 32'h204};
        for (int i = 0; i < 10; i++) begin
            pc = 32'h208 + 32'(4 * i);
            inst_valid       = 1'b1;
            inst_pc          = pc;
            inst             = r_type(5'd4);
            micro_code_ready = 1'b1;
            #1;
            tests_run++;
            if (occupancy !== 3'd2 || micro_code_valid !== 1'b1 || inst_ready !== 1'b1 ||
                micro_code.pc !== exp_q[0]) begin
                tests_failed++;
                $display("FAIL b2b_%0d got occ=%0d v=%b rdy=%b pc=%h want occ=2 v=1 rdy=1 pc=%h",
                         i, occupancy, micro_code_valid, inst_ready, micro_code.pc, exp_q[0]);
            end
            void'(exp_q.pop_front());
            exp_q.push_back(pc);
            @(negedge clk);
        end
        inst_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            tests_run++;
            if (micro_code_valid !== 1'b1 || micro_code.pc !== exp_q[0]) begin
                tests_failed++;
                $display("FAIL b2b_drain_%0d got v=%b pc=%h want v=1 pc=%h", i, micro_code_valid, micro_code.pc, exp_q[0]);
            end
            void'(exp_q.pop_front());
            @(negedge clk);
        end
        #1;
        tests_run++;
        if (micro_code_valid !== 1'b0 || occupancy !== 3'd0) begin
            tests_failed++;
            $display("FAIL b2b_empty got v=%b occ=%0d want v=0 occ=0", micro_code_valid, occupancy);
        end
    endtask

    task automatic test_flush;
        push_stalled(32'h300, 3);
        inst_valid = 1'b1;
        inst_pc    = 32'h30C;
        inst       = r_type(5'd5);
        flush      = 1'b1;
        #1;
        tests_run++;
        if (occupancy !== 3'd3 || inst_ready !== 1'b0 || micro_code_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_cycle got occ=%0d rdy=%b v=%b want occ=3 rdy=0 v=0", occupancy, inst_ready, micro_code_valid);
        end
        @(negedge clk);
        flush = 1'b0;
        inst_valid = 1'b0;
        #1;
        tests_run++;
        if (occupancy !== 3'd0 || micro_code_valid !== 1'b0 || inst_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_after got occ=%0d v=%b rdy=%b want occ=0 v=0 rdy=1", occupancy, micro_code_valid, inst_ready);
        end
        @(negedge clk);
        micro_code_ready = 1'b1;
        inst_valid = 1'b1;
        inst_pc    = 32'h400;
        @(negedge clk);
        inst_valid = 1'b0;
        #1;
        tests_run++;
        if (micro_code_valid !== 1'b1 || micro_code.pc !== 32'h400) begin
            tests_failed++;
            $display("FAIL flush_next_pc got v=%b pc=%h want v=1 pc=00000400", micro_code_valid, micro_code.pc);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (micro_code_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_dropped_reappeared got v=%b pc=%h want v=0", micro_code_valid, micro_code.pc);
        end
    endtask

    task automatic test_flush_hold;
        push_stalled(32'h500, 2);
        inst_valid = 1'b1;
        inst_pc    = 32'h508;
        flush      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++;
            if (micro_code_valid !== 1'b0 || inst_ready !== 1'b0 || (i > 0 && occupancy !== 3'd0)) begin
                tests_failed++;
                $display("FAIL flush_hold_%0d got v=%b rdy=%b occ=%0d want v=0 rdy=0", i, micro_code_valid, inst_ready, occupancy);
            end
            @(negedge clk);
        end
        flush = 1'b0;
        inst_valid = 1'b0;
        #1;
        tests_run++;
        if (occupancy !== 3'd0 || micro_code_valid !== 1'b0 || inst_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_hold_release got occ=%0d v=%b rdy=%b want occ=0 v=0 rdy=1", occupancy, micro_code_valid, inst_ready);
        end
    endtask

    task automatic test_mid_reset;
        push_stalled(32'h600, 4);
        #1;
        tests_run++;
        if (occupancy !== 3'd4 || inst_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset_full got occ=%0d rdy=%b want occ=4 rdy=0", occupancy, inst_ready);
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (occupancy !== 3'd0 || micro_code_valid !== 1'b0 || inst_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_reset_after got occ=%0d v=%b rdy=%b want occ=0 v=0 rdy=1", occupancy, micro_code_valid, inst_ready);
        end
    endtask

    task automatic test_random;
        int n_sent = 0;
        int n_recv = 0;
        int cycles = 0;
        bit drop_next = 1'b0;
        bit prev_stall = 1'b0;
        bit accepted;
        bit popped;
        micro_code_t saved;
        logic [31:0] idx;
        exp_q.delete();
        while (n_recv < 1000 && cycles < 20000) begin
            @(negedge clk);
            if (drop_next) inst_valid = 1'b0;
            if (!inst_valid && n_sent < 1000 && $urandom_range(0, 9) < 7) begin
                inst_valid = 1'b1;
                inst_pc    = 32'h1000 + 32'(4 * n_sent);
                inst       = r_type(5'(n_sent));
            end
            micro_code_ready = ($urandom_range(0, 9) < 6);
            #1;
            tests_run++;
            if (inst_ready !== (exp_q.size() < DEPTH) || micro_code_valid !== (exp_q.size() != 0)) begin
                tests_failed++;
                $display("FAIL rand_flags got rdy=%b v=%b with %0d queued", inst_ready, micro_code_valid, exp_q.size());
            end
            if (exp_q.size() != 0) begin
                idx = (exp_q[0] - 32'h1000) >> 2;
                tests_run++;
                if (micro_code.pc !== exp_q[0] || micro_code.rd !== idx[4:0]) begin
                    tests_failed++;
                    $display("FAIL rand_head got pc=%h rd=%0d want pc=%h rd=%0d", micro_code.pc, micro_code.rd, exp_q[0], idx[4:0]);
                end
            end
            if (prev_stall) begin
                tests_run++;
                if (micro_code !== saved) begin
                    tests_failed++;
                    $display("FAIL rand_stable got %h want %h", micro_code, saved);
                end
            end
            accepted   = inst_valid && (exp_q.size() < DEPTH);
            popped     = (exp_q.size() != 0) && micro_code_ready;
            prev_stall = (exp_q.size() != 0) && !micro_code_ready;
            saved      = micro_code;
            if (popped) begin
                void'(exp_q.pop_front());
                n_recv++;
            end
            if (accepted) begin
                exp_q.push_back(inst_pc);
                n_sent++;
            end
            drop_next = accepted;
            cycles++;
        end
        tests_run++;
        if (n_recv != 1000) begin
            tests_failed++;
            $display("FAIL rand_timeout got %0d received want 1000", n_recv);
        end
        @(negedge clk);
        inst_valid = 1'b0;
        micro_code_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_decode();
        test_latency();
        test_full();
        test_back_to_back();
        test_flush();
        test_flush_hold();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
